bloom_req_ctrl: RTL and testbench

- Request front-end for the Bloom filter core (insert/check/clear on a shared data bus, 1-bit match output).
- Accepts tagged operations over a valid/ready interface and buffers them in a small FIFO.
- Issues each operation to the core as a single-cycle strobe, holds it off until the core's hash/update/compare pipeline has settled, then returns a tagged response through a valid/ready interface.
- Serialises operations, so an insert is always visible to any later check.

---
 rtl/bloom_pkg.sv | 30 +++
 rtl/bloom_req_ctrl_if.sv | 31 +++
 rtl/bloom_req_fifo.sv | 55 +++++
 rtl/bloom_req_ctrl.sv | 140 ++++++++++++++
 tb/tb_bloom_req_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bloom_pkg.sv
// Shared types for the Bloom filter request front-end.
// Op codes, controller states and the default request bundle.
package bloom_pkg;

    localparam int D_SIZE_DEF = 32;
    localparam int TAG_W_DEF  = 4;

    typedef enum logic [1:0] {
        OP_INSERT = 2'b00,
        OP_CHECK  = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    // Request at the default widths; modules with other widths
    // declare their own bundle of the same shape.
    typedef struct packed {
        op_e                   op;
        logic [D_SIZE_DEF-1:0] data;
        logic [TAG_W_DEF-1:0]  tag;
    } req_t;

endpackage

// File: rtl/bloom_req_ctrl_if.sv
// Request/response handshake bundle for bloom_req_ctrl.
// master: requester/consumer side; slave: the controller.
interface bloom_req_ctrl_if #(
    parameter int D_SIZE = 32,
    parameter int TAG_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [D_SIZE-1:0] req_data;
    logic [TAG_W-1:0]  req_tag;

    logic              resp_valid;
    logic              resp_ready;
    logic [1:0]        resp_op;
    logic [TAG_W-1:0]  resp_tag;
    logic              resp_match;
    logic              resp_err;

    modport master (
        output req_valid, req_op, req_data, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_op, resp_tag,
        input  resp_match, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_data, req_tag, resp_ready,
        output req_ready, resp_valid, resp_op, resp_tag,
        output resp_match, resp_err
    );
endinterface

// File: rtl/bloom_req_fifo.sv
// Synchronous request FIFO, async active-high reset.
// Ports: push/wdata in, pop/rdata out (show-ahead), full/empty/count.
module bloom_req_fifo
    import bloom_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = req_t
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  T                           wdata,
    input  logic                       pop,
    output T                           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/bloom_req_ctrl.sv
// Bloom filter request front-end: FIFO-buffered, serialised ops,
// one-cycle core strobes, tagged responses.
// Ports: clk, reset, bus (slave handshake), bf_* core side, busy.
module bloom_req_ctrl
    import bloom_pkg::*;
#(
    parameter int D_SIZE     = 32,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int MATCH_LAT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    bloom_req_ctrl_if.slave   bus,
    output logic              bf_insert,
    output logic              bf_check,
    output logic              bf_clear,
    output logic [D_SIZE-1:0] bf_data,
    input  logic              bf_match,
    output logic              busy
);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = (MATCH_LAT > 1) ? $clog2(MATCH_LAT) : 1;

    typedef struct packed {
        op_e               op;
        logic [D_SIZE-1:0] data;
        logic [TAG_W-1:0]  tag;
    } req_w_t;

    state_e             state;
    state_e             state_nx;
    op_e                op_q;
    logic [D_SIZE-1:0]  data_q;
    logic [TAG_W-1:0]   tag_q;
    logic [CNT_W-1:0]   cnt;
    logic               match_q;
    logic               err_q;

    req_w_t             fifo_in;
    req_w_t             fifo_out;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic               pop;

    assign fifo_in.op   = op_e'(bus.req_op);
    assign fifo_in.data = bus.req_data;
    assign fifo_in.tag  = bus.req_tag;

    bloom_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (req_w_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.req_valid),
        .wdata (fifo_in),
        .pop   (pop),
        .rdata (fifo_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Reserved ops never touch the core.
                if (op_q == OP_RSVD) state_nx = S_RESP;
                else                 state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == '0) state_nx = S_RESP;
            end
            S_RESP: begin
                if (bus.resp_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q    <= OP_INSERT;
            data_q  <= '0;
            tag_q   <= '0;
            cnt     <= '0;
            match_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (pop) begin
                op_q    <= fifo_out.op;
                data_q  <= fifo_out.data;
                tag_q   <= fifo_out.tag;
                match_q <= 1'b0;
                err_q   <= 1'b0;
            end
            if (state == S_ISSUE) begin
                cnt   <= CNT_W'(MATCH_LAT - 1);
                err_q <= (op_q == OP_RSVD);
            end
            if (state == S_WAIT) begin
                cnt <= cnt - 1'b1;
                // Core result is settled on the last wait cycle.
                if (cnt == '0)
                    match_q <= (op_q == OP_CHECK) && bf_match;
            end
        end
    end

    // Strobes decode registered state only, so they cannot glitch.
    assign bf_insert = (state == S_ISSUE) && (op_q == OP_INSERT);
    assign bf_check  = (state == S_ISSUE) && (op_q == OP_CHECK);
    assign bf_clear  = (state == S_ISSUE) && (op_q == OP_CLEAR);
    assign bf_data   = data_q;

    assign bus.req_ready  = !fifo_full;
    assign bus.resp_valid = (state == S_RESP);
    assign bus.resp_op    = op_q;
    assign bus.resp_tag   = tag_q;
    assign bus.resp_match = match_q;
    assign bus.resp_err   = err_q;

    assign busy = (state != S_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_bloom_req_ctrl.sv
// Scoreboard bench for bloom_req_ctrl with a behavioural core model.
// Ports: drives clk/reset, bus master side, bf_match from the model.
module tb_bloom_req_ctrl;
    import bloom_pkg::*;

    localparam int D     = 32;
    localparam int TW    = 4;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          bf_insert;
    logic          bf_check;
    logic          bf_clear;
    logic [D-1:0]  bf_data;
    logic          bf_match;
    logic          busy;

    bloom_req_ctrl_if #(.D_SIZE(D), .TAG_W(TW)) bus();

    bloom_req_ctrl #(
        .D_SIZE     (D),
        .TAG_W      (TW),
        .FIFO_DEPTH (DEPTH),
        .MATCH_LAT  (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .bf_insert (bf_insert),
        .bf_check  (bf_check),
        .bf_clear  (bf_clear),
        .bf_data   (bf_data),
        .bf_match  (bf_match),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Core model: keys updated at the strobe edge, match after LAT.
    bit            core_keys [logic [D-1:0]];
    logic [LAT-1:0] pipe = '0;

    always @(posedge clk) begin
        pipe <= {pipe[LAT-2:0], bf_check && core_keys.exists(bf_data)};
        if (bf_insert) core_keys[bf_data] = 1'b1;
        if (bf_clear)  core_keys.delete();
    end
    assign bf_match = pipe[LAT-1];

    // Reference model and scoreboard, updated in acceptance order.
    typedef struct {
        logic [1:0]    op;
        logic [TW-1:0] tag;
        logic          match;
        logic          err;
    } exp_t;

    exp_t sbq [$];
    bit   ref_keys [logic [D-1:0]];

    task automatic sb_push(input logic [1:0] op, input logic [D-1:0] data,
                           input logic [TW-1:0] tag);
        exp_t e;
        e.op    = op;
        e.tag   = tag;
        e.match = 1'b0;
        e.err   = (op == 2'b11);
        case (op)
            2'b00: ref_keys[data] = 1'b1;
            2'b01: e.match = ref_keys.exists(data);
            2'b10: ref_keys.delete();
            default: ;
        endcase
        sbq.push_back(e);
    endtask

    // Monitor
    int   cyc = 0;
    int   chk_cyc, ins_cyc, clr_cyc, rise_cyc;
    int   n_strobe = 0, n_clr = 0, onehot_bad = 0;
    int   clr_run = 0, clr_run_max = 0;
    logic rv_d = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            rv_d = 1'b0;
        end else begin
            if (int'(bf_insert) + int'(bf_check) + int'(bf_clear) > 1)
                onehot_bad++;
            n_strobe += int'(bf_insert) + int'(bf_check) + int'(bf_clear);
            if (bf_check)  chk_cyc = cyc;
            if (bf_insert) ins_cyc = cyc;
            if (bf_clear) begin
                clr_cyc = cyc;
                n_clr++;
                clr_run++;
                if (clr_run > clr_run_max) clr_run_max = clr_run;
            end else begin
                clr_run = 0;
            end
            if (bus.resp_valid && !rv_d) rise_cyc = cyc;
            rv_d = bus.resp_valid;
            if (bus.resp_valid && bus.resp_ready) begin
                if (sbq.size() == 0) begin
                    chk("resp_unexpected", 64'(sbq.size()), 64'd1);
                end else begin
                    e = sbq.pop_front();
                    chk("resp_op",    64'(bus.resp_op),    64'(e.op));
                    chk("resp_tag",   64'(bus.resp_tag),   64'(e.tag));
                    chk("resp_match", 64'(bus.resp_match), 64'(e.match));
                    chk("resp_err",   64'(bus.resp_err),   64'(e.err));
                end
            end
        end
    end

    // Called and returns at posedge+1.
    task automatic push(input logic [1:0] op, input logic [D-1:0] data,
                        input logic [TW-1:0] tag, input int budget,
                        output bit acc);
        acc           = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_data  = data;
        bus.req_tag   = tag;
        for (int i = 0; i < budget && !acc; i++) begin
            @(negedge clk);
            if (bus.req_ready) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        if (acc) sb_push(op, data, tag);
    endtask

    task automatic push_ok(input logic [1:0] op, input logic [D-1:0] data,
                           input logic [TW-1:0] tag);
        bit acc;
        push(op, data, tag, 20, acc);
        chk($sformatf("accept_t%0d", tag), 64'(acc), 64'd1);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((sbq.size() != 0 || busy) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_drain"}, 64'(sbq.size() == 0 && !busy), 64'd1);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_strobes"}, 64'({bf_insert, bf_check, bf_clear}), 64'd0);
        chk({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
        chk({tag, "_bf_data"}, 64'(bf_data), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, s0, c0, seen;
        bit acc;

        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'b00;
        bus.req_data   = '0;
        bus.req_tag    = '0;
        bus.resp_ready = 1'b1;
        #1;
        chk_idle_outs("reset");
        tick(3);
        reset = 1'b0;
        tick(1);
        chk_idle_outs("post_reset");

        // Single CHECK latency
        t0 = cyc;
        push_ok(2'b01, 32'hDEADBEEF, 4'd3);
        wait_drain("t1", 40);
        chk("t1_check_cyc", 64'(chk_cyc - t0), 64'd2);
        chk("t1_rise_cyc", 64'(rise_cyc - t0), 64'(3 + LAT));

        // INSERT then CHECK back to back
        push_ok(2'b00, 32'h1234, 4'd1);
        push_ok(2'b01, 32'h1234, 4'd2);
        wait_drain("t2", 40);
        chk("t2_spacing_ge_lat", 64'(chk_cyc - ins_cyc >= LAT), 64'd1);

        // Backpressure: 4 in FIFO + 1 in flight
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push(2'b01, 32'(i), 4'(10 + i), 12, acc);
            chk($sformatf("bp_acc%0d", i), 64'(acc), 64'(i < 5));
        end
        chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
        chk("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
        chk("bp_pending", 64'(sbq.size()), 64'd5);
        bus.resp_ready = 1'b1;
        wait_drain("bp", 80);

        // INSERT, CLEAR, CHECK
        c0          = n_clr;
        clr_run_max = 0;
        push_ok(2'b00, 32'hAA, 4'd4);
        push_ok(2'b10, 32'h0, 4'd7);
        push_ok(2'b01, 32'hAA, 4'd8);
        wait_drain("t4", 60);
        chk("t4_clr_count", 64'(n_clr - c0), 64'd1);
        chk("t4_clr_width", 64'(clr_run_max), 64'd1);
        chk("t4_clr_after_ins", 64'(clr_cyc > ins_cyc), 64'd1);

        // Reserved op
        s0 = n_strobe;
        t0 = cyc;
        push_ok(2'b11, 32'h99, 4'd9);
        wait_drain("t5", 30);
        chk("t5_rise_cyc", 64'(rise_cyc - t0), 64'd3);
        chk("t5_no_strobe", 64'(n_strobe - s0), 64'd0);

        // Reset during WAIT
        t0 = cyc;
        push_ok(2'b01, 32'h55, 4'd5);
        for (int i = 0; i < 20 && cyc < t0 + 3; i++) tick(1);
        chk("t6_wait_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk_idle_outs("t6_async");
        sbq.delete();
        tick(2);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus.resp_valid) seen++;
        end
        chk("t6_no_resp", 64'(seen), 64'd0);
        chk("t6_idle_busy", 64'(busy), 64'd0);
        push_ok(2'b00, 32'h77, 4'd6);
        t0 = cyc;
        push_ok(2'b01, 32'h77, 4'd11);
        wait_drain("t6", 40);
        chk("t6_chk_after_ins", 64'(chk_cyc > ins_cyc), 64'd1);

        chk("onehot", 64'(onehot_bad), 64'd0);
        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
